// File: rtl/rf_pkg.sv
// Shared register-file write types, used by the write arbiter, the register file and the hazard unit.
package rf_pkg;
   localparam int REG_ADDR_W = 4;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 16;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] dest;
      logic [DATA_W-1:0]     value;
   } rf_wr_req_t;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
      return {{(NUM_REGS-1){1'b0}}, 1'b1} << r;
   endfunction
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback, auxiliary-producer and register-file write signals of the write arbiter.
interface rf_write_arbiter_if;
   import rf_pkg::*;

   logic                  wb_valid;
   logic [REG_ADDR_W-1:0] wb_dest;
   logic [DATA_W-1:0]     wb_value;
   logic                  aux_valid;
   logic                  aux_ready;
   logic [REG_ADDR_W-1:0] aux_dest;
   logic [DATA_W-1:0]     aux_value;
   logic                  rf_wr_en;
   logic [REG_ADDR_W-1:0] rf_wr_dest;
   logic [DATA_W-1:0]     rf_wr_value;
   logic [NUM_REGS-1:0]   pending_mask;
   logic                  hold_req;

   modport master (
      output wb_valid, wb_dest, wb_value, aux_valid, aux_dest, aux_value,
      input  aux_ready, rf_wr_en, rf_wr_dest, rf_wr_value, pending_mask, hold_req
   );

   modport slave (
      input  wb_valid, wb_dest, wb_value, aux_valid, aux_dest, aux_value,
      output aux_ready, rf_wr_en, rf_wr_dest, rf_wr_value, pending_mask, hold_req
   );
endinterface

// File: rtl/rf_wr_fifo.sv
// Small synchronous FIFO of register writes with per-entry valid/dest taps for the pending mask.
module rf_wr_fifo
   import rf_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              push,
   input  logic                              pop,
   input  rf_wr_req_t                        push_req,
   output rf_wr_req_t                        head,
   output logic                              full,
   output logic                              empty,
   output logic [DEPTH-1:0]                  tap_valid,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]  tap_dest
);
   localparam int PTR_W = $clog2(DEPTH);

   rf_wr_req_t       mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_reg == (PTR_W+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem_reg[rd_ptr_reg];

   // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_reg[wr_ptr_reg] <= push_req;
   end

   // An entry is live when its distance from the read pointer is below the occupancy.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
      logic [PTR_W-1:0] offset;
      assign offset        = PTR_W'(gi) - rd_ptr_reg;
      assign tap_valid[gi] = ({1'b0, offset} < count_reg);
      assign tap_dest[gi]  = mem_reg[gi].dest;
   end
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port: pipeline writeback first, queued or bypassed aux writes on free cycles.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int AUX_DEPTH    = 2,
   parameter int STARVE_LIMIT = 8
) (
   input logic               clk,
   input logic               rst,
   rf_write_arbiter_if.slave bus
);
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   rf_wr_req_t                          aux_req;
   rf_wr_req_t                          fifo_head;
   rf_wr_req_t                          grant_req;
   logic                                fifo_full;
   logic                                fifo_empty;
   logic [AUX_DEPTH-1:0]                tap_valid;
   logic [AUX_DEPTH-1:0][REG_ADDR_W-1:0] tap_dest;
   logic [AUX_DEPTH-1:0][NUM_REGS-1:0]  entry_mask;
   logic                                aux_xfer;
   logic                                push;
   logic                                pop;
   logic                                grant_valid;
   logic                                grant_aux;
   logic [STARVE_W-1:0]                 starve_next;

   logic                                wr_en_reg;
   rf_wr_req_t                          wr_req_reg;
   logic                                wr_aux_reg;
   logic [STARVE_W-1:0]                 starve_reg;
   logic                                hold_reg;
   logic [NUM_REGS-1:0]                 mask_next;

   assign aux_req       = '{dest: bus.aux_dest, value: bus.aux_value};
   assign bus.aux_ready = !fifo_full;

   rf_wr_fifo #(.DEPTH(AUX_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_req  (aux_req),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .tap_valid (tap_valid),
      .tap_dest  (tap_dest)
   );

   always_comb begin
      aux_xfer    = bus.aux_valid && !fifo_full;
      pop         = !bus.wb_valid && !fifo_empty;
      push        = aux_xfer && (bus.wb_valid || !fifo_empty);
      grant_valid = 1'b1;
      grant_aux   = 1'b0;
      grant_req   = '{dest: bus.wb_dest, value: bus.wb_value};
      if (bus.wb_valid) begin
         grant_aux = 1'b0;
      end else if (!fifo_empty) begin
         grant_req = fifo_head;
         grant_aux = 1'b1;
      end else if (aux_xfer) begin
         grant_req = aux_req;
         grant_aux = 1'b1;
      end else begin
         grant_valid = 1'b0;
      end

      if (fifo_empty || pop)
         starve_next = '0;
      else if (starve_reg < STARVE_W'(STARVE_LIMIT))
         starve_next = starve_reg + 1'b1;
      else
         starve_next = starve_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_reg  <= 1'b0;
         wr_req_reg <= '0;
         wr_aux_reg <= 1'b0;
         starve_reg <= '0;
         hold_reg   <= 1'b0;
      end else begin
         wr_en_reg  <= grant_valid;
         if (grant_valid) wr_req_reg <= grant_req;
         wr_aux_reg <= grant_valid && grant_aux;
         starve_reg <= starve_next;
         hold_reg   <= (starve_next >= STARVE_W'(STARVE_LIMIT));
      end
   end

   // Queued entries plus an aux write currently being presented keep their register marked.
   for (genvar gi = 0; gi < AUX_DEPTH; gi++) begin : g_entry_mask
      assign entry_mask[gi] = tap_valid[gi] ? reg_onehot(tap_dest[gi]) : '0;
   end

   always_comb begin
      mask_next = wr_aux_reg ? reg_onehot(wr_req_reg.dest) : '0;
      for (int i = 0; i < AUX_DEPTH; i++) mask_next = mask_next | entry_mask[i];
   end

   assign bus.rf_wr_en     = wr_en_reg;
   assign bus.rf_wr_dest   = wr_req_reg.dest;
   assign bus.rf_wr_value  = wr_req_reg.value;
   assign bus.pending_mask = mask_next;
   assign bus.hold_req     = hold_reg;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed vector table plus randomized traffic against a queue-based reference model.
module tb_rf_write_arbiter;
   import rf_pkg::*;

   localparam int DEPTH = 2;
   localparam int LIMIT = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rf_write_arbiter_if bus ();

   rf_write_arbiter #(.AUX_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests  = 0;
   int failed = 0;

   typedef struct {
      bit          r;
      bit          wbv;
      logic [3:0]  wbd;
      logic [31:0] wbval;
      bit          av;
      logic [3:0]  ad;
      logic [31:0] aval;
      bit          e_ready;
      bit          e_en;
      logic [3:0]  e_dest;
      logic [31:0] e_value;
      logic [15:0] e_mask;
      bit          e_hold;
   } vec_t;

   vec_t vecs[$];

   // Reference model: a plain queue of accepted aux writes plus the head's waiting time.
   rf_wr_req_t  mq[$];
   bit          m_en;
   logic [3:0]  m_dest;
   logic [31:0] m_value;
   bit          m_aux_bus;
   int          m_wait;
   bit          m_hold;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         failed++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [15:0] model_mask();
      logic [15:0] m;
      m = m_aux_bus ? (16'h1 << m_dest) : 16'h0;
      foreach (mq[i]) m = m | (16'h1 << mq[i].dest);
      return m;
   endfunction

   task automatic model_step(input bit r, input bit wbv, input logic [3:0] wbd, input logic [31:0] wbval,
                             input bit av, input logic [3:0] ad, input logic [31:0] aval);
      bit xfer, was_empty, popped;
      rf_wr_req_t h;
      if (r) begin
         mq.delete();
         m_en = 0; m_dest = 0; m_value = 0; m_aux_bus = 0; m_wait = 0; m_hold = 0;
         return;
      end
      xfer      = av && (mq.size() < DEPTH);
      was_empty = (mq.size() == 0);
      popped    = 0;
      m_aux_bus = 0;
      if (wbv) begin
         m_en = 1; m_dest = wbd; m_value = wbval;
         if (xfer) mq.push_back('{dest: ad, value: aval});
      end else if (!was_empty) begin
         h = mq.pop_front();
         m_en = 1; m_dest = h.dest; m_value = h.value; m_aux_bus = 1; popped = 1;
         if (xfer) mq.push_back('{dest: ad, value: aval});
      end else if (xfer) begin
         m_en = 1; m_dest = ad; m_value = aval; m_aux_bus = 1;
      end else begin
         m_en = 0;
      end
      if (was_empty || popped) m_wait = 0;
      else if (m_wait < LIMIT) m_wait = m_wait + 1;
      m_hold = (m_wait >= LIMIT);
   endtask

   // Starts and ends at a negedge: drive, check ready, clock, then check registered outputs.
   task automatic run_cycle(input string tag, input bit r, input bit wbv, input logic [3:0] wbd,
                            input logic [31:0] wbval, input bit av, input logic [3:0] ad,
                            input logic [31:0] aval, output bit rdy_seen);
      rst           = r;
      bus.wb_valid  = wbv;
      bus.wb_dest   = wbd;
      bus.wb_value  = wbval;
      bus.aux_valid = av;
      bus.aux_dest  = ad;
      bus.aux_value = aval;
      #1;
      rdy_seen = bus.aux_ready;
      chk({tag, " model aux_ready"}, 32'(rdy_seen), 32'(mq.size() < DEPTH));
      @(posedge clk);
      model_step(r, wbv, wbd, wbval, av, ad, aval);
      @(negedge clk);
      chk({tag, " model rf_wr_en"}, 32'(bus.rf_wr_en), 32'(m_en));
      chk({tag, " model rf_wr_dest"}, 32'(bus.rf_wr_dest), 32'(m_dest));
      chk({tag, " model rf_wr_value"}, bus.rf_wr_value, m_value);
      chk({tag, " model pending_mask"}, 32'(bus.pending_mask), 32'(model_mask()));
      chk({tag, " model hold_req"}, 32'(bus.hold_req), 32'(m_hold));
      $display("[TB] %s rst=%0b wb=%0b/%0d aux=%0b/%0d rdy=%0b -> en=%0b d=%0d v=%h mask=%h hold=%0b",
               tag, r, wbv, wbd, av, ad, rdy_seen, bus.rf_wr_en, bus.rf_wr_dest, bus.rf_wr_value,
               bus.pending_mask, bus.hold_req);
   endtask

   function automatic vec_t mk(bit r, bit wbv, logic [3:0] wbd, logic [31:0] wbval,
                               bit av, logic [3:0] ad, logic [31:0] aval,
                               bit er, bit een, logic [3:0] ed, logic [31:0] ev,
                               logic [15:0] em, bit eh);
      vec_t v;
      v.r = r; v.wbv = wbv; v.wbd = wbd; v.wbval = wbval; v.av = av; v.ad = ad; v.aval = aval;
      v.e_ready = er; v.e_en = een; v.e_dest = ed; v.e_value = ev; v.e_mask = em; v.e_hold = eh;
      return v;
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          rdy;
      bit          off_v;
      logic [3:0]  off_d;
      logic [31:0] off_val;
      bit          r_i, wbv_i;
      int          wb_pct;

      // Pipeline only, bypass, collision
      vecs.push_back(mk(0,1,3,32'hDEADBEEF,0,0,0, 1,1,3,32'hDEADBEEF,16'h0000,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,             1,0,3,32'hDEADBEEF,16'h0000,0));
      vecs.push_back(mk(0,0,0,0,1,5,32'h11,       1,1,5,32'h11,16'h0020,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,             1,0,5,32'h11,16'h0000,0));
      vecs.push_back(mk(0,1,1,32'h100,1,2,32'h200, 1,1,1,32'h100,16'h0004,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,             1,1,2,32'h200,16'h0004,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,             1,0,2,32'h200,16'h0000,0));
      // Full FIFO: two accepts, then the third offer waits until the drain frees a slot
      vecs.push_back(mk(0,1,10,32'hA0,1,6,32'h600, 1,1,10,32'hA0,16'h0040,0));
      vecs.push_back(mk(0,1,10,32'hA1,1,7,32'h700, 1,1,10,32'hA1,16'h00C0,0));
      for (int k = 2; k < 6; k++)
         vecs.push_back(mk(0,1,10,32'hA0+k,1,8,32'h800, 0,1,10,32'hA0+k,16'h00C0,0));
      vecs.push_back(mk(0,0,0,0,1,8,32'h800,       0,1,6,32'h600,16'h00C0,0));
      vecs.push_back(mk(0,0,0,0,1,8,32'h800,       1,1,7,32'h700,16'h0180,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,             1,1,8,32'h800,16'h0100,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,             1,0,8,32'h800,16'h0000,0));
      // Starvation: head waits 8 cycles, hold on the 9th, stays while wb ignores it
      vecs.push_back(mk(0,1,11,32'hB0,1,9,32'h900, 1,1,11,32'hB0,16'h0200,0));
      for (int k = 1; k <= 9; k++)
         vecs.push_back(mk(0,1,11,32'hB0+k,0,0,0,  1,1,11,32'hB0+k,16'h0200,(k >= 8)));
      vecs.push_back(mk(0,0,0,0,0,0,0,             1,1,9,32'h900,16'h0200,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,             1,0,9,32'h900,16'h0000,0));
      // Reset with two queued entries discards them
      vecs.push_back(mk(0,1,12,32'hC0,1,13,32'hD0, 1,1,12,32'hC0,16'h2000,0));
      vecs.push_back(mk(0,1,12,32'hC1,1,14,32'hE0, 1,1,12,32'hC1,16'h6000,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,             0,0,0,32'h0,16'h0000,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,             1,0,0,32'h0,16'h0000,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,             1,0,0,32'h0,16'h0000,0));

      bus.wb_valid = 0; bus.wb_dest = 0; bus.wb_value = 0;
      bus.aux_valid = 0; bus.aux_dest = 0; bus.aux_value = 0;
      @(negedge clk);
      run_cycle("reset0", 1, 0, 0, 0, 0, 0, 0, rdy);
      run_cycle("reset1", 1, 0, 0, 0, 0, 0, 0, rdy);
      rst = 0;
      #1;
      chk("reset rf_wr_en", 32'(bus.rf_wr_en), 32'd0);
      chk("reset rf_wr_dest", 32'(bus.rf_wr_dest), 32'd0);
      chk("reset rf_wr_value", bus.rf_wr_value, 32'd0);
      chk("reset pending_mask", 32'(bus.pending_mask), 32'd0);
      chk("reset hold_req", 32'(bus.hold_req), 32'd0);
      chk("reset aux_ready", 32'(bus.aux_ready), 32'd1);
      @(negedge clk);

      foreach (vecs[i]) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         run_cycle(tag, vecs[i].r, vecs[i].wbv, vecs[i].wbd, vecs[i].wbval,
                   vecs[i].av, vecs[i].ad, vecs[i].aval, rdy);
         chk({tag, " aux_ready"}, 32'(rdy), 32'(vecs[i].e_ready));
         chk({tag, " rf_wr_en"}, 32'(bus.rf_wr_en), 32'(vecs[i].e_en));
         chk({tag, " rf_wr_dest"}, 32'(bus.rf_wr_dest), 32'(vecs[i].e_dest));
         chk({tag, " rf_wr_value"}, bus.rf_wr_value, vecs[i].e_value);
         chk({tag, " pending_mask"}, 32'(bus.pending_mask), 32'(vecs[i].e_mask));
         chk({tag, " hold_req"}, 32'(bus.hold_req), 32'(vecs[i].e_hold));
      end

      // Random traffic; an offer stays stable until it is accepted
      off_v = 0; off_d = 0; off_val = 0; wb_pct = 50;
      for (int c = 0; c < 400; c++) begin
         if (c % 32 == 0) wb_pct = ($urandom_range(0, 1) == 1) ? 95 : 35;
         if (!off_v && $urandom_range(0, 99) < 60) begin
            off_v   = 1;
            off_d   = 4'($urandom_range(0, 15));
            off_val = $urandom;
         end
         r_i   = ($urandom_range(0, 149) == 0);
         wbv_i = ($urandom_range(0, 99) < wb_pct);
         run_cycle($sformatf("rnd%0d", c), r_i, wbv_i, 4'($urandom_range(0, 15)), $urandom,
                   off_v, off_d, off_val, rdy);
         if (!r_i && off_v && rdy) off_v = 0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
